mem_arbiter: RTL and testbench

- Shares one single-ported synchronous program/data RAM between three requesters: program loader (emulation host), pipeline data port (MEM stage) and pipeline instruction port (IF stage).
- Serialises accesses with a small FSM, fixed priority plus instruction anti-starvation.
- Returns per-requester ack pulses that the CPU converts to stalls.
- Sits between the five-stage core and the memory macro.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the three-way RAM arbiter.
//   arb_state_t : arbiter FSM states
//   req_sel_t   : requester selector, value doubles as the ack bit index
//   CNT_W       : starvation counter width for the default STARVE_MAX
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} arb_state_t;

    typedef enum logic [1:0] {SEL_LD, SEL_D, SEL_I} req_sel_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = $clog2(STARVE_MAX_DEF + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational priority picker (ld > d > i, or ld > i > d when starved).
//   i_ld_req, i_d_req, i_i_req : requests
//   i_starve                   : instruction port has waited STARVE_MAX cycles
//   o_grant                    : one-hot grant, bit index = req_sel_t value
//   o_valid                    : at least one request is active
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_ld_req,
    input  logic       i_d_req,
    input  logic       i_i_req,
    input  logic       i_starve,
    output logic [2:0] o_grant,
    output logic       o_valid
);

    always_comb begin
        o_grant[SEL_LD] = i_ld_req;
        o_grant[SEL_D]  = !i_ld_req && i_d_req && !(i_starve && i_i_req);
        o_grant[SEL_I]  = !i_ld_req && i_i_req && (i_starve || !i_d_req);
        o_valid         = i_ld_req || i_d_req || i_i_req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises loader, data and instruction accesses onto one synchronous RAM.
//   clk, rst_n                       : clock, synchronous active-low reset
//   ld_req/ld_we/ld_addr/ld_wdata    : loader request, acked on ld_ack
//   d_req/d_we/d_addr/d_wdata        : data port request, read data on d_rdata, acked on d_ack
//   i_req/i_addr                     : instruction read request, data on i_rdata, acked on i_ack
//   m_en/m_we/m_addr/m_wdata/m_rdata : RAM macro interface (read latency MEM_LAT)
//   busy                             : FSM not in IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = STARVE_MAX_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    r_state;
    req_sel_t      r_sel;
    logic          r_we;
    logic [1:0]    r_lat;
    logic [SW-1:0] r_starve;
    logic [2:0]    r_ack;
    logic [DW-1:0] r_d_rdata;
    logic [DW-1:0] r_i_rdata;
    logic          r_m_en;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;

    logic [2:0]    w_grant;
    logic          w_valid;
    logic          w_starve;
    logic          w_i_win;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    req_sel_t      w_sel;

    assign w_starve = (r_starve == SW'(STARVE_MAX));

    mem_arb_pick u_pick (
        .i_ld_req (ld_req),
        .i_d_req  (d_req),
        .i_i_req  (i_req),
        .i_starve (w_starve),
        .o_grant  (w_grant),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_sel   = w_grant[SEL_LD] ? SEL_LD : w_grant[SEL_D] ? SEL_D : SEL_I;
        w_we    = w_grant[SEL_LD] ? ld_we : w_grant[SEL_D] ? d_we : 1'b0;
        w_addr  = w_grant[SEL_LD] ? ld_addr : w_grant[SEL_D] ? d_addr : i_addr;
        w_wdata = w_grant[SEL_LD] ? ld_wdata : w_grant[SEL_D] ? d_wdata : '0;
        w_i_win = (r_state == IDLE) && w_grant[SEL_I];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= SEL_LD;
            r_we      <= 1'b0;
            r_lat     <= '0;
            r_starve  <= '0;
            r_ack     <= '0;
            r_d_rdata <= '0;
            r_i_rdata <= '0;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            // strobes and acks are single-cycle; address/data hold their last value
            r_ack    <= '0;
            r_m_en   <= 1'b0;
            r_m_we   <= 1'b0;
            r_starve <= (!i_req || w_i_win) ? '0 : w_starve ? r_starve : r_starve + SW'(1);
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state   <= ACCESS;
                        r_sel     <= w_sel;
                        r_we      <= w_we;
                        r_m_en    <= 1'b1;
                        r_m_we    <= w_we;
                        r_m_addr  <= w_addr;
                        r_m_wdata <= w_wdata;
                    end
                end
                ACCESS: begin
                    if (r_we || MEM_LAT == 1) begin
                        r_state <= DONE;
                        r_ack   <= 3'b001 << r_sel;
                    end else begin
                        r_state <= WAIT;
                        r_lat   <= '0;
                    end
                end
                WAIT: begin
                    // MEM_LAT-1 cycles spent here: counts 0 .. MEM_LAT-2
                    if (r_lat == 2'(MEM_LAT - 2)) begin
                        r_state <= DONE;
                        r_ack   <= 3'b001 << r_sel;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    if (!r_we && r_sel == SEL_D) r_d_rdata <= m_rdata;
                    if (!r_we && r_sel == SEL_I) r_i_rdata <= m_rdata;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ld_ack  = r_ack[SEL_LD];
    assign d_ack   = r_ack[SEL_D];
    assign i_ack   = r_ack[SEL_I];
    assign d_rdata = r_d_rdata;
    assign i_rdata = r_i_rdata;
    assign m_en    = r_m_en;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench; one arbiter with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic ld_req, ld_we, d_req, d_we, i_req;
    logic [AW-1:0] ld_addr, d_addr, i_addr;
    logic [DW-1:0] ld_wdata, d_wdata;

    logic ld_ack, d_ack, i_ack, m_en, m_we, busy;
    logic [DW-1:0] d_rdata, i_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;

    logic ld_ack3, d_ack3, i_ack3, m_en3, m_we3, busy3;
    logic [DW-1:0] d_rdata3, i_rdata3, m_wdata3, m_rdata3;
    logic [AW-1:0] m_addr3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata3), .d_ack(d_ack3),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
        .busy(busy3)
    );

    // RAM models: latency 1 for u_dut, latency 3 for u_dut3
    logic [DW-1:0] mem1 [128];
    logic [DW-1:0] mem3 [128];
    logic [DW-1:0] rd1;
    logic [DW-1:0] p3 [3];
    bit loaded;

    function automatic logic [DW-1:0] init_word(int a);
        return (a == 5) ? 32'h2002_0001 : 32'h1000_0000 + a;
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 128; a++) begin
                mem1[a] <= init_word(a);
                mem3[a] <= init_word(a);
            end
            loaded <= 1'b1;
        end else begin
            if (m_en && m_we) mem1[m_addr] <= m_wdata;
            if (m_en && !m_we) rd1 <= mem1[m_addr];
            if (m_en3 && m_we3) mem3[m_addr3] <= m_wdata3;
        end
        p3[0] <= (m_en3 && !m_we3) ? mem3[m_addr3] : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign m_rdata  = rd1;
    assign m_rdata3 = p3[2];

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i_req = 0; i_addr = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst_n = 0;
        step(2);
        rst_n = 1;
    endtask

    task automatic test_reset();
        ld_req = 1; ld_we = 0; ld_addr = 7'd1; ld_wdata = 32'h1111_1111;
        d_req = 1; d_we = 0; d_addr = 7'd2; d_wdata = 32'h2222_2222;
        i_req = 1; i_addr = 7'd3;
        rst_n = 0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            checks++;
            if ({ld_ack, d_ack, i_ack, m_en, m_we, busy, m_addr, m_wdata, d_rdata, i_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outs cyc%0d: acks=%b en=%b we=%b busy=%b addr=%h wd=%h dr=%h ir=%h, want all 0",
                         c, {ld_ack, d_ack, i_ack}, m_en, m_we, busy, m_addr, m_wdata, d_rdata, i_rdata);
            end
            checks++;
            if ({ld_ack3, d_ack3, i_ack3, m_en3, m_we3, busy3, m_addr3, m_wdata3, d_rdata3, i_rdata3} !== '0) begin
                errors++;
                $display("FAIL reset_outs3 cyc%0d: acks=%b en=%b busy=%b addr=%h, want all 0",
                         c, {ld_ack3, d_ack3, i_ack3}, m_en3, busy3, m_addr3);
            end
        end
        rst_n = 1;
        step(1);
        checks++;
        if ({m_en, m_we, m_addr, busy} !== {1'b1, 1'b0, 7'd1, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_grant: en=%b we=%b addr=%0d busy=%b, want en=1 we=0 addr=1 busy=1",
                     m_en, m_we, m_addr, busy);
        end
        step(1);
        checks++;
        if ({ld_ack, d_ack, i_ack} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ld_ack: acks(ld,d,i)=%b, want 100", {ld_ack, d_ack, i_ack});
        end
        clear_reqs();
        step(1);
        checks++;
        if ({ld_ack, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ld_done: ld_ack=%b busy=%b, want 0 0", ld_ack, busy);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        i_req = 1; i_addr = 7'd5;
        step(1);
        checks++;
        if ({m_en, m_we, m_addr, i_ack} !== {1'b1, 1'b0, 7'd5, 1'b0}) begin
            errors++;
            $display("FAIL single_access: en=%b we=%b addr=%0d i_ack=%b, want 1 0 5 0", m_en, m_we, m_addr, i_ack);
        end
        step(1);
        checks++;
        if ({ld_ack, d_ack, i_ack, m_en} !== 4'b0010) begin
            errors++;
            $display("FAIL single_ack: acks(ld,d,i)=%b en=%b, want 001 0", {ld_ack, d_ack, i_ack}, m_en);
        end
        i_req = 0;
        step(1);
        checks++;
        if ({i_ack, i_rdata} !== {1'b0, 32'h2002_0001}) begin
            errors++;
            $display("FAIL single_rdata: i_ack=%b i_rdata=%h, want 0 20020001", i_ack, i_rdata);
        end
    endtask

    task automatic test_contention();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 7'd3; d_wdata = 32'hDEAD_BEEF;
        i_req = 1; i_addr = 7'd5;
        step(1);
        checks++;
        if ({m_en, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 7'd3, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL cont_d_first: en=%b we=%b addr=%0d wd=%h, want 1 1 3 deadbeef", m_en, m_we, m_addr, m_wdata);
        end
        step(1);
        checks++;
        if ({ld_ack, d_ack, i_ack} !== 3'b010) begin
            errors++;
            $display("FAIL cont_d_ack: acks(ld,d,i)=%b, want 010", {ld_ack, d_ack, i_ack});
        end
        d_req = 0; d_we = 0;
        step(1);
        checks++;
        if ({d_ack, busy, d_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL cont_after_write: d_ack=%b busy=%b d_rdata=%h, want 0 0 0", d_ack, busy, d_rdata);
        end
        step(1);
        checks++;
        if ({m_en, m_we, m_addr} !== {1'b1, 1'b0, 7'd5}) begin
            errors++;
            $display("FAIL cont_i_second: en=%b we=%b addr=%0d, want 1 0 5", m_en, m_we, m_addr);
        end
        step(1);
        checks++;
        if ({ld_ack, d_ack, i_ack} !== 3'b001) begin
            errors++;
            $display("FAIL cont_i_ack: acks(ld,d,i)=%b, want 001", {ld_ack, d_ack, i_ack});
        end
        i_req = 0;
        d_req = 1; d_we = 0; d_addr = 7'd3;
        step(1);
        checks++;
        if (i_rdata !== 32'h2002_0001) begin
            errors++;
            $display("FAIL cont_i_rdata: i_rdata=%h, want 20020001", i_rdata);
        end
        step(2);
        checks++;
        if ({ld_ack, d_ack, i_ack} !== 3'b010) begin
            errors++;
            $display("FAIL cont_readback_ack: acks(ld,d,i)=%b, want 010", {ld_ack, d_ack, i_ack});
        end
        d_req = 0;
        step(1);
        checks++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cont_readback: d_rdata=%h, want deadbeef", d_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [11:0] en_exp, dack_exp, iack_exp;
        en_exp   = 12'b0010_0100_1001;
        dack_exp = 12'b0100_0001_0010;
        iack_exp = 12'b0000_1000_0000;
        do_reset();
        d_req = 1; d_we = 1; d_addr = 7'd10; d_wdata = 32'hCAFE_0010;
        i_req = 1; i_addr = 7'd5;
        for (int j = 0; j < 12; j++) begin
            step(1);
            checks++;
            if ({ld_ack, d_ack, i_ack, m_en} !== {1'b0, dack_exp[j], iack_exp[j], en_exp[j]}) begin
                errors++;
                $display("FAIL starve_seq j=%0d: acks(ld,d,i)=%b en=%b, want %b%b%b %b",
                         j, {ld_ack, d_ack, i_ack}, m_en, 1'b0, dack_exp[j], iack_exp[j], en_exp[j]);
            end
            if (j == 6 || j == 9) begin
                checks++;
                if (m_addr !== ((j == 6) ? 7'd5 : 7'd10)) begin
                    errors++;
                    $display("FAIL starve_grant j=%0d: m_addr=%0d, want %0d", j, m_addr, (j == 6) ? 5 : 10);
                end
            end
        end
        clear_reqs();
        step(3);
    endtask

    task automatic test_lat3_reset();
        do_reset();
        i_req = 1; i_addr = 7'd20;
        step(1);
        checks++;
        if ({m_en3, m_addr3} !== {1'b1, 7'd20}) begin
            errors++;
            $display("FAIL lat3_access: en=%b addr=%0d, want 1 20", m_en3, m_addr3);
        end
        step(1);
        checks++;
        if ({m_en3, busy3, i_ack3} !== 3'b010) begin
            errors++;
            $display("FAIL lat3_wait: en=%b busy=%b i_ack=%b, want 0 1 0", m_en3, busy3, i_ack3);
        end
        rst_n = 0;
        step(1);
        checks++;
        if ({i_ack3, busy3, m_en3, m_addr3, i_rdata3} !== '0) begin
            errors++;
            $display("FAIL lat3_abort: i_ack=%b busy=%b en=%b addr=%0d ir=%h, want all 0",
                     i_ack3, busy3, m_en3, m_addr3, i_rdata3);
        end
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            checks++;
            if ({m_en3, i_ack3} !== {k == 0, k == 3}) begin
                errors++;
                $display("FAIL lat3_reissue k=%0d: en=%b i_ack=%b, want %b %b", k, m_en3, i_ack3, k == 0, k == 3);
            end
        end
        i_req = 0;
        step(1);
        checks++;
        if ({i_ack3, i_rdata3} !== {1'b0, 32'h1000_0014}) begin
            errors++;
            $display("FAIL lat3_rdata: i_ack=%b i_rdata=%h, want 0 10000014", i_ack3, i_rdata3);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] en_exp, ack_exp, busy_exp;
        en_exp   = 8'b0100_1001;
        ack_exp  = 8'b1001_0010;
        busy_exp = 8'b1101_1011;
        do_reset();
        i_req = 1; i_addr = 7'd5;
        for (int j = 0; j < 8; j++) begin
            step(1);
            checks++;
            if ({m_en, i_ack, busy, ld_ack, d_ack} !== {en_exp[j], ack_exp[j], busy_exp[j], 2'b00}) begin
                errors++;
                $display("FAIL b2b j=%0d: en=%b i_ack=%b busy=%b ld/d_ack=%b%b, want %b %b %b 00",
                         j, m_en, i_ack, busy, ld_ack, d_ack, en_exp[j], ack_exp[j], busy_exp[j]);
            end
        end
        i_req = 0;
        step(2);
    endtask

    initial begin
        clear_reqs();
        rst_n = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_starvation();
        test_lat3_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
